multibyte_add_seq: RTL and testbench

Multi-cycle controller that adds or subtracts two NBYTES-byte operands using one shared 8-bit adder (two cascaded 4-bit carry-lookahead stages), one byte per clock, least-significant byte first. It owns the operand and result registers, the inter-byte carry register and a start/done handshake. It sits between a requester, such as an ALU sequencer or testbench driver, and the single 8-bit adder instance, which it instantiates internally.

---
 rtl/multibyte_add_seq_if.sv | 26 ++
 rtl/multibyte_add_seq.sv | 177 +++++++++++++++++
 tb/tb_multibyte_add_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/multibyte_add_seq_if.sv
// Request/response bundle for the byte-serial add/subtract controller.
// The master drives operands and start; the slave returns status and result.
`timescale 1ns/1ps
interface multibyte_add_seq_if #(
    parameter int unsigned NBYTES = 4
);
    logic                  start;
    logic                  sub;
    logic [8*NBYTES-1:0]   a;
    logic [8*NBYTES-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [8*NBYTES-1:0]   result;
    logic                  cout;
    logic                  overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/multibyte_add_seq.sv
// Byte-serial NBYTES-wide add/subtract controller around one shared 8-bit
// carry-lookahead adder, least-significant byte first.
`timescale 1ns/1ps
module multibyte_add_seq_cla4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = x & y;
        p    = x ^ y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module multibyte_add_seq_adder8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic c_mid;

    multibyte_add_seq_cla4 u_lo (
        .x    (x[3:0]),
        .y    (y[3:0]),
        .cin  (cin),
        .sum  (sum[3:0]),
        .cout (c_mid)
    );

    multibyte_add_seq_cla4 u_hi (
        .x    (x[7:4]),
        .y    (y[7:4]),
        .cin  (c_mid),
        .sum  (sum[7:4]),
        .cout (cout)
    );
endmodule

module multibyte_add_seq #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    multibyte_add_seq_if.slave   bus
);
    localparam int unsigned W     = 8 * NBYTES;
    localparam int unsigned IDX_W = $clog2(NBYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       opa_q, opa_d;
    logic [W-1:0]       opb_q, opb_d;
    logic [W-1:0]       result_q, result_d;
    logic               sub_q, sub_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [7:0]         add_x;
    logic [7:0]         add_y;
    logic [7:0]         add_sum;
    logic               add_cout;
    logic               last_byte;

    // Subtraction is a + ~b + 1: the +1 comes from the carry preload at start.
    always_comb begin
        add_x     = opa_q[8*int'(idx_q) +: 8];
        add_y     = opb_q[8*int'(idx_q) +: 8] ^ {8{sub_q}};
        last_byte = (idx_q == IDX_W'(NBYTES - 1));
    end

    multibyte_add_seq_adder8 u_adder (
        .x    (add_x),
        .y    (add_y),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    opa_d    = bus.a;
                    opb_d    = bus.b;
                    sub_d    = bus.sub;
                    idx_d    = '0;
                    carry_d  = bus.sub;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                result_d[8*int'(idx_q) +: 8] = add_sum;
                carry_d = add_cout;
                if (last_byte) begin
                    cout_d  = add_cout;
                    ovf_d   = (add_x[7] == add_y[7]) && (add_sum[7] != add_x[7]);
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed bench for multibyte_add_seq with NBYTES=4: arithmetic corner
// cases, handshake timing, held start and mid-operation reset.
`timescale 1ns/1ps
module tb_multibyte_add_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    multibyte_add_seq_if #(.NBYTES(4)) bus ();

    multibyte_add_seq #(.NBYTES(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for done after the accepting edge; returns edges taken and busy samples.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.done && edges < 20) begin
            step();
            edges++;
            if (bus.busy) busy_cnt++;
        end
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                          input logic [31:0] er, input logic ec, input logic eo,
                          input string tag);
        int edges;
        int busy_cnt;
        bus.a     = av;
        bus.b     = bv;
        bus.sub   = sv;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk({tag, "_busy_rise"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, "_res_clear"}, bus.result, 32'd0);
        // Scramble inputs during RUN; the latched operands must be used.
        bus.a   = ~av;
        bus.b   = ~bv;
        bus.sub = ~sv;
        wait_done(edges, busy_cnt);
        chk({tag, "_done_lat"}, edges, 32'd4);
        chk({tag, "_result"}, bus.result, er);
        chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
        chk({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, eo});
        step();
        busy_cnt += bus.busy ? 1 : 0;
        chk({tag, "_busy_cycles"}, busy_cnt, 32'd5);
        chk({tag, "_done_fall"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_hold"}, bus.result, er);
    endtask

    initial begin
        int edges;
        int busy_cnt;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        step();
        step();
        step();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_cout", {31'd0, bus.cout}, 32'd0);
        chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        rst = 1'b0;
        step();

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_ripple");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
        run_op(32'h0001_00FF, 32'h0000_FF01, 1'b0, 32'h0002_0000, 1'b0, 1'b0, "add_mid");

        // Start held high: second request is taken only once back in IDLE.
        bus.a     = 32'h0000_0010;
        bus.b     = 32'h0000_0020;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        step();
        bus.a = 32'h0000_0100;
        bus.b = 32'h0000_0200;
        wait_done(edges, busy_cnt);
        chk("held_first_lat", edges, 32'd4);
        chk("held_first_res", bus.result, 32'h0000_0030);
        step();
        chk("held_idle_gap", {31'd0, bus.busy}, 32'd0);
        chk("held_gap_res", bus.result, 32'h0000_0030);
        step();
        bus.start = 1'b0;
        chk("held_second_acc", {31'd0, bus.busy}, 32'd1);
        chk("held_second_clr", bus.result, 32'd0);
        wait_done(edges, busy_cnt);
        chk("held_second_lat", edges, 32'd4);
        chk("held_second_res", bus.result, 32'h0000_0300);
        step();

        // Reset sampled on the second edge of an operation.
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'h0000_0001;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
